// File: rtl/mem_req_queue_if.sv
// mem_req_pkg / mem_req_queue_if
// Purpose: memory request payload type and the bus bundle between the
//          AGEN->LSU latch, the request queue and the LSU.
// Signals (slave = queue side):
//   flush_i      in   recover/exception flush, discard all requests
//   memPacket_i  in   request from AgenLsu, .valid qualifies it
//   lsuReady_i   in   LSU accepts head request this cycle
//   memPacket_o  out  head request, .valid = request present
//   stall_o      out  block memory-pipe selection in the issue queue
//   count_o      out  current occupancy ($clog2(DEPTH)+1 bits)
//   overflow_o   out  sticky error: valid request arrived while full

package mem_req_pkg;

    // One memory-pipe request as latched between AGEN and LSU.
    typedef struct packed {
        logic        valid;
        logic        isStore;
        logic [4:0]  lsqId;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } memPkt;

endpackage

interface mem_req_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush_i;
    mem_req_pkg::memPkt memPacket_i;
    logic               lsuReady_i;
    mem_req_pkg::memPkt memPacket_o;
    logic               stall_o;
    logic [CNT_W-1:0]   count_o;
    logic               overflow_o;

    // Pipeline / LSU side.
    modport master (
        output flush_i, memPacket_i, lsuReady_i,
        input  memPacket_o, stall_o, count_o, overflow_o
    );

    // Queue side.
    modport slave (
        input  flush_i, memPacket_i, lsuReady_i,
        output memPacket_o, stall_o, count_o, overflow_o
    );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue
// Purpose: in-order FIFO between the AGEN->LSU latch and the LSU. Absorbs
//          requests while the LSU is busy, raises stall_o early enough that
//          in-flight ops (STALL_SLACK) never overflow it, and is emptied by a
//          flush.
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous, active-high reset
//   bus    mem_req_queue_if.slave (flush_i, memPacket_i, lsuReady_i in;
//          memPacket_o, stall_o, count_o, overflow_o out)
// Parameters: DEPTH (power of 2, >=2), STALL_SLACK (ops between select and
//          this queue).
// Configuration macro: MEM_REQ_BYPASS_EN -- when defined, a request arriving
//          at an empty queue with the LSU ready is passed straight through
//          combinationally and never written.

module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_SLACK = 2
) (
    input logic            clk,
    input logic            reset,
    mem_req_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_TH  = CNT_W'(DEPTH - STALL_SLACK);

    memPkt            entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic [PTR_W-1:0] headNext;
    logic [PTR_W-1:0] tailNext;
    logic [CNT_W-1:0] countNext;
    logic             overflowNext;

    logic  full;
    logic  empty;
    logic  inValid;
    logic  deq;
    logic  enq;
    logic  bypass;
    memPkt outPkt;

    // Handshake decode and next-state for pointers, counter and overflow flag.
    always_comb begin
        full         = (count == DEPTH_CNT);
        empty        = (count == '0);
        inValid      = bus.memPacket_i.valid;
        bypass       = 1'b0;
`ifdef MEM_REQ_BYPASS_EN
        bypass       = empty & inValid & bus.lsuReady_i & ~bus.flush_i;
`endif
        // Flush freezes the handshake: head stays visible but is not consumed.
        deq          = ~empty & bus.lsuReady_i & ~bus.flush_i;
        // A full queue still accepts when the head leaves in the same cycle.
        enq          = inValid & ~bus.flush_i & ~bypass & (~full | deq);

        headNext     = head + PTR_W'(deq);
        tailNext     = tail + PTR_W'(enq);
        countNext    = count + CNT_W'(enq) - CNT_W'(deq);
        overflowNext = overflow | (inValid & full & ~deq & ~bus.flush_i);

        if (bus.flush_i) begin
            headNext  = '0;
            tailNext  = '0;
            countNext = '0;
        end
    end

    // Pointer, occupancy and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            head     <= headNext;
            tail     <= tailNext;
            count    <= countNext;
            overflow <= overflowNext;
        end
    end

    // Request storage; cleared on reset so stale payloads never leak out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (enq) begin
            entries[tail] <= bus.memPacket_i;
        end
    end

    // Head presentation; an empty queue shows an all-zero packet.
    always_comb begin
        outPkt = '0;
        if (!empty) begin
            outPkt = entries[head];
        end
        if (bypass) begin
            outPkt = bus.memPacket_i;
        end
    end

    assign bus.memPacket_o = outPkt;
    // Stall depends on the count register only, never on lsuReady_i.
    assign bus.stall_o     = (count >= STALL_TH);
    assign bus.count_o     = count;
    assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue
// Purpose: randomized and directed stimulus for mem_req_queue, compared each
//          cycle against a queue-based reference model of the request FIFO.

module tb_mem_req_queue;
    import mem_req_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SLACK = 2;
`ifdef MEM_REQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_req_queue_if #(.DEPTH(DEPTH)) bus ();

    mem_req_queue #(
        .DEPTH       (DEPTH),
        .STALL_SLACK (SLACK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending requests in order, sticky error, delivery count.
    memPkt       modelQ[$];
    bit          modelOvf  = 1'b0;
    int          delivered = 0;
    int unsigned nextPc    = 32'h200;

    task automatic checkVal(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic memPkt makePkt(input bit v, input logic [31:0] pc);
        memPkt p;
        p.valid   = v;
        p.isStore = 1'($urandom);
        p.lsqId   = 5'($urandom);
        p.pc      = pc;
        p.addr    = $urandom;
        p.data    = $urandom;
        return p;
    endfunction

    function automatic memPkt freshPkt();
        nextPc = nextPc + 4;
        return makePkt(1'b1, nextPc);
    endfunction

    function automatic bit modelStall();
        return modelQ.size() >= int'(DEPTH - SLACK);
    endfunction

    // One clock: drive at negedge, compare before the edge, advance the model.
    task automatic step(input memPkt inPkt, input bit rdy, input bit fl);
        memPkt expOut;
        bit    wasFull;
        bit    take;
        bit    byp;
        @(negedge clk);
        bus.memPacket_i = inPkt;
        bus.lsuReady_i  = rdy;
        bus.flush_i     = fl;
        #1;
        byp = BYPASS && modelQ.size() == 0 && inPkt.valid && rdy && !fl;
        if (byp)                   expOut = inPkt;
        else if (modelQ.size() > 0) expOut = modelQ[0];
        else                       expOut = '0;
        checkVal("count",    128'(bus.count_o),    128'(modelQ.size()));
        checkVal("stall",    128'(bus.stall_o),    128'(modelStall()));
        checkVal("overflow", 128'(bus.overflow_o), 128'(modelOvf));
        checkVal("head",     128'(bus.memPacket_o), 128'(expOut));
        if (fl) begin
            modelQ.delete();
        end else begin
            wasFull = modelQ.size() == int'(DEPTH);
            take    = modelQ.size() > 0 && rdy;
            if (take) begin
                void'(modelQ.pop_front());
                delivered++;
            end
            if (byp) delivered++;
            if (inPkt.valid && !byp) begin
                if (!wasFull || take) modelQ.push_back(inPkt);
                else                  modelOvf = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    // Asynchronous reset asserted between edges; everything must clear at once.
    task automatic applyReset();
        @(negedge clk);
        bus.memPacket_i = '0;
        bus.lsuReady_i  = 1'b0;
        bus.flush_i     = 1'b0;
        reset = 1'b1;
        #1;
        checkVal("rst_count",    128'(bus.count_o),           128'(0));
        checkVal("rst_valid",    128'(bus.memPacket_o.valid), 128'(0));
        checkVal("rst_stall",    128'(bus.stall_o),           128'(0));
        checkVal("rst_overflow", 128'(bus.overflow_o),        128'(0));
        modelQ.delete();
        modelOvf = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int startDel;
        int sent;
        bus.memPacket_i = '0;
        bus.lsuReady_i  = 1'b0;
        bus.flush_i     = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        applyReset();

        // Single request, LSU ready: visible the following cycle.
        step(makePkt(1'b1, 32'h100), 1'b1, 1'b0);
`ifndef MEM_REQ_BYPASS_EN
        #1;
        checkVal("lat_valid", 128'(bus.memPacket_o.valid), 128'(1));
        checkVal("lat_pc",    128'(bus.memPacket_o.pc),    128'(32'h100));
`endif
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // Five back-to-back requests, LSU blocked: stall at 2, fifth dropped.
        for (int i = 0; i < 5; i++) step(freshPkt(), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);

        // Full queue with simultaneous enqueue and dequeue for six cycles.
        for (int i = 0; i < 6; i++) step(freshPkt(), 1'b1, 1'b0);

        // Drop to three entries, then flush with a valid request present.
        step('0, 1'b1, 1'b0);
        step(freshPkt(), 1'b1, 1'b1);
        step('0, 1'b0, 1'b0);
        step(freshPkt(), 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // Three entries pending, then reset mid-stream.
        for (int i = 0; i < 3; i++) step(freshPkt(), 1'b0, 1'b0);
        applyReset();

        // Ten requests with LSU toggling; issue honours stall, so none lost.
        startDel = delivered;
        sent = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            if (!modelStall()) begin
                step(freshPkt(), c[0], 1'b0);
                sent++;
            end else begin
                step('0, c[0], 1'b0);
            end
        end
        for (int i = 0; i < int'(DEPTH) + 2; i++) step('0, 1'b1, 1'b0);
        checkVal("stream_delivered", 128'(delivered - startDel), 128'(10));
        checkVal("stream_overflow",  128'(bus.overflow_o),       128'(0));

        // Random traffic: mostly stall-honouring issue, occasional flush/reset.
        for (int c = 0; c < 400; c++) begin
            bit    v;
            memPkt p;
            if ($urandom_range(99) == 0) begin
                applyReset();
            end else begin
                v = ($urandom_range(99) < 65) &&
                    (!modelStall() || $urandom_range(9) == 0);
                p = v ? freshPkt() : makePkt(1'b0, $urandom);
                step(p, 1'($urandom), $urandom_range(19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
